// File: rtl/bgp_enable_seq_pkg.sv
// bgp_enable_seq_pkg: state encoding and default timing for the bandgap enable sequencer
package bgp_enable_seq_pkg;
  localparam int ST_W = 2;
  localparam int DEF_SETTLE_CYCLES = 1000;
  localparam int DEF_OFF_CYCLES = 100;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [ST_W-1:0] {
    ST_OFF       = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_READY     = 2'd2,
    ST_DISCHARGE = 2'd3
  } state_t;
endpackage

// File: rtl/bgp_down_counter.sv
// bgp_down_counter: loadable down counter that holds at zero, with a zero flag
module bgp_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (!o_zero) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/bgp_enable_seq.sv
// bgp_enable_seq: bandgap EN sequencer with settle delay before ready and minimum discharge time
module bgp_enable_seq
  import bgp_enable_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int OFF_CYCLES    = DEF_OFF_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic             force_off,
  input  logic [CNT_W-1:0] settle_cfg,
  output logic             bg_en,
  output logic             bg_ready,
  output logic [ST_W-1:0]  state
);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_M1    = CNT_W'(OFF_CYCLES - 1);
  state_t           r_state, w_next;
  logic             r_bg_en, r_bg_ready;
  logic             w_on, w_zero, w_load;
  logic [CNT_W-1:0] w_settle, w_load_val;
  assign w_on     = req && !force_off;
  assign w_settle = (settle_cfg != '0) ? settle_cfg - 1'b1 : SETTLE_M1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_OFF:       w_next = w_on ? ST_SETTLE : ST_OFF;
      ST_SETTLE:    w_next = !w_on ? ST_DISCHARGE : w_zero ? ST_READY : ST_SETTLE;
      ST_READY:     w_next = w_on ? ST_READY : ST_DISCHARGE;
      ST_DISCHARGE: w_next = w_zero ? ST_OFF : ST_DISCHARGE;
    endcase
  end
  // counter is reloaded on every state change; only SETTLE and DISCHARGE use its value
  assign w_load     = w_next != r_state;
  assign w_load_val = (w_next == ST_SETTLE) ? w_settle : (w_next == ST_DISCHARGE) ? OFF_M1 : '0;
  bgp_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_zero    (w_zero)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state    <= ST_OFF;
      r_bg_en    <= 1'b0;
      r_bg_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_bg_en    <= (w_next == ST_SETTLE) || (w_next == ST_READY);
      r_bg_ready <= w_next == ST_READY;
    end
  assign bg_en    = r_bg_en;
  assign bg_ready = r_bg_ready;
  assign state    = r_state;
endmodule

// File: tb/tb_bgp_enable_seq.sv
// tb_bgp_enable_seq: directed vector table plus multi-cycle sequences for bgp_enable_seq
module tb_bgp_enable_seq;
  logic clk = 1'b0, resetn = 1'b0;
  logic req0 = 1'b0, frc0 = 1'b0, req1 = 1'b0, frc1 = 1'b0;
  logic [15:0] cfg0 = '0, cfg1 = '0;
  logic en0, rdy0, en1, rdy1;
  logic [1:0] st0, st1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  bgp_enable_seq #(.SETTLE_CYCLES(1000), .OFF_CYCLES(100), .CNT_W(16)) dut0 (
    .clk(clk), .resetn(resetn), .req(req0), .force_off(frc0), .settle_cfg(cfg0),
    .bg_en(en0), .bg_ready(rdy0), .state(st0));
  bgp_enable_seq #(.SETTLE_CYCLES(3), .OFF_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .resetn(resetn), .req(req1), .force_off(frc1), .settle_cfg(cfg1),
    .bg_en(en1), .bg_ready(rdy1), .state(st1));
  typedef struct {
    logic        req;
    logic        frc;
    logic [15:0] cfg;
    logic [1:0]  st;
    logic        en;
    logic        rdy;
  } vec_t;
  vec_t tbl[20];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic inv();
    chk("inv0", 32'((!rdy0 || (en0 && st0 == 2'd2)) && (en0 == (st0 == 2'd1 || st0 == 2'd2))), 1);
    chk("inv1", 32'((!rdy1 || (en1 && st1 == 2'd2)) && (en1 == (st1 == 2'd1 || st1 == 2'd2))), 1);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    inv();
  endtask
  task automatic go_off();
    int n;
    req0 = 1'b0;
    n = 0;
    while (st0 != 2'd0 && n < 300) begin
      tick();
      n++;
    end
    chk("go_off", 32'(st0), 0);
  endtask
  initial begin
    int n;
    logic saw;
    tbl[0]  = '{1'b0, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 16'd0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'd2, 2'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'd0, 2'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'd0, 2'd2, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 16'd0, 2'd2, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 16'd0, 2'd3, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'd1, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'd1, 2'd2, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 16'd0, 2'd3, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'd0, 2'd1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 16'd0, 2'd1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 16'd0, 2'd3, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 16'd0, 2'd1, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 16'd0, 2'd1, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 16'd0, 2'd1, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 16'd0, 2'd2, 1'b1, 1'b1};
    #12;
    chk("reset0", 32'({st0, en0, rdy0}), 0);
    chk("reset1", 32'({st1, en1, rdy1}), 0);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req1 = tbl[i].req;
      frc1 = tbl[i].frc;
      cfg1 = tbl[i].cfg;
      tick();
      chk($sformatf("vec%0d", i), 32'({st1, en1, rdy1}), 32'({tbl[i].st, tbl[i].en, tbl[i].rdy}));
    end
    cfg1 = 16'd1;
    frc1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      req1 = ~req1;
      tick();
    end
    req1 = 1'b0;
    req0 = 1'b1;
    tick();
    chk("s1000_en", 32'({st0, en0, rdy0}), 32'({2'd1, 1'b1, 1'b0}));
    n = 0;
    while (!rdy0 && n < 2000) begin
      tick();
      n++;
    end
    chk("s1000_lat", 32'(n), 1000);
    chk("s1000_st", 32'(st0), 2);
    req0 = 1'b0;
    tick();
    chk("drop_req", 32'({st0, en0, rdy0}), 32'({2'd3, 1'b0, 1'b0}));
    req0 = 1'b1;
    n = 0;
    while (!en0 && n < 300) begin
      tick();
      n++;
    end
    chk("off_time", 32'(n), 101);
    chk("resettle_st", 32'(st0), 1);
    go_off();
    cfg0 = 16'd5;
    req0 = 1'b1;
    tick();
    chk("s5_en", 32'(en0), 1);
    n = 0;
    while (!rdy0 && n < 100) begin
      tick();
      n++;
      if (n == 2) cfg0 = 16'd50;
    end
    chk("s5_lat", 32'(n), 5);
    go_off();
    cfg0 = 16'd0;
    req0 = 1'b1;
    tick();
    saw = 1'b0;
    repeat (300) begin
      tick();
      saw |= rdy0;
    end
    frc0 = 1'b1;
    tick();
    chk("abort", 32'({st0, en0, rdy0, saw}), 32'({2'd3, 1'b0, 1'b0, 1'b0}));
    repeat (150) tick();
    chk("force_hold", 32'({st0, en0, rdy0}), 0);
    frc0 = 1'b0;
    cfg0 = 16'd3;
    tick();
    chk("rst_settle", 32'(st0), 1);
    repeat (3) tick();
    chk("rst_ready", 32'({st0, en0, rdy0}), 32'({2'd2, 1'b1, 1'b1}));
    #2 resetn = 1'b0;
    #1;
    chk("async_rst", 32'({st0, en0, rdy0}), 0);
    resetn = 1'b1;
    tick();
    chk("post_rst", 32'({st0, en0, rdy0}), 32'({2'd1, 1'b1, 1'b0}));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bgp_enable_seq.md
Name: bgp_enable_seq

Overview:
- Digital sequencer directly upstream of the 3.3 V bandgap macro.
- Drives the bandgap EN pin from a level request (SoC register or SPI bit).
- Enforces a settle interval before asserting bg_ready to consumers (ADC, LDO, comparators).
- Enforces a minimum off (discharge) interval before the bandgap may be re-enabled.

Parameters:
- SETTLE_CYCLES, 1000: default settle time in clk cycles from bg_en rise to bg_ready rise; must be >= 1.
- OFF_CYCLES, 100: minimum cycles spent in DISCHARGE after bg_en falls; must be >= 1.
- CNT_W, 16: counter width; SETTLE_CYCLES, OFF_CYCLES and 2^CNT_W-1 must all fit.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- req  input  1  level request for bandgap on; synchronous to clk
- force_off  input  1  override, forces shutdown; higher priority than req
- settle_cfg  input  CNT_W  runtime settle override; 0 selects SETTLE_CYCLES
- bg_en  output  1  drives bandgap EN, registered
- bg_ready  output  1  bandgap outputs valid, registered
- state  output  2  OFF=0, SETTLE=1, READY=2, DISCHARGE=3

Behaviour:
- Reset (resetn low, async): state=OFF, bg_en=0, bg_ready=0, cnt=0. All outputs are registered; no combinational path from input to output.
- Settle value S = settle_cfg if nonzero, else SETTLE_CYCLES. S is sampled only on the OFF->SETTLE edge; later settle_cfg changes do not affect a settle already in progress.
- OFF:
  - req=1 and force_off=0 -> SETTLE, bg_en<=1, cnt<=S-1.
  - Otherwise stay in OFF.
- SETTLE:
  - force_off=1 or req=0 -> DISCHARGE (abort).
  - Else if cnt==0 -> READY, bg_ready<=1.
  - Else cnt<=cnt-1.
  - Timing: bg_en rises at edge k; bg_ready rises at edge k+S. S=1 gives bg_ready exactly one cycle after bg_en.
- READY:
  - bg_en=1, bg_ready=1.
  - force_off=1 or req=0 -> DISCHARGE.
- DISCHARGE:
  - Entry edge: bg_en<=0, bg_ready<=0 (both drop on the same edge), cnt<=OFF_CYCLES-1.
  - If cnt==0 -> OFF, else cnt<=cnt-1. req is ignored while in DISCHARGE.
  - Exactly OFF_CYCLES cycles are spent in DISCHARGE.
  - If req is still 1 and force_off=0 on arrival in OFF, SETTLE is entered on the next edge. Minimum bg_en low time is therefore OFF_CYCLES+1 cycles.
- Priority: force_off > req. force_off has no effect in OFF or DISCHARGE beyond holding the block in OFF.
- Invariants:
  - bg_ready=1 implies bg_en=1 and state==READY.
  - bg_en=1 exactly when state is SETTLE or READY.
- Reset asserted mid-SETTLE or mid-READY: bg_en and bg_ready go to 0 immediately (async); no DISCHARGE interval is enforced after reset release.
- Counter never wraps: it decrements only while nonzero and is reloaded on every state entry.
- settle_cfg=all-ones gives the maximum settle of 2^CNT_W-1 cycles.

Decomposition:
- Shared package: state encoding constants (ST_OFF, ST_SETTLE, ST_READY, ST_DISCHARGE), 2-bit state width, default timing constants.
- One natural sub-module, bgp_down_counter: loadable, CNT_W-bit, with a zero flag. Shared by the SETTLE and DISCHARGE timing; the FSM stays in the top level.

Test Plan:
- Reset then req=1, settle_cfg=0, SETTLE_CYCLES=1000 -> bg_en rises 1 cycle after req; bg_ready rises exactly 1000 cycles after bg_en; state goes 0->1->2.
- settle_cfg=5, req=1 -> bg_ready 5 cycles after bg_en. Change settle_cfg to 50 mid-settle -> still 5.
- In READY, drop req -> bg_en and bg_ready fall on the same edge, state=3. With req reasserted immediately, bg_en stays low OFF_CYCLES+1 (101) cycles, then SETTLE restarts.
- req=1, then pulse force_off at settle cycle 300 -> DISCHARGE, bg_ready never asserts. Hold force_off with req=1 -> block remains in OFF.
- Assert resetn=0 while READY -> bg_en=0, bg_ready=0 without waiting for a clock edge. Release with req=1 -> SETTLE on the first edge.
- settle_cfg=1 and OFF_CYCLES=1 boundary -> bg_ready 1 cycle after bg_en. Toggling req every cycle never produces bg_ready=1 while bg_en=0 (checked by assertion throughout).
